mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer_pkg.sv | 28 ++
 rtl/mem_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mem_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sequencer_pkg.sv
// Shared definitions for the memory sequencer: state encoding, RAM
// direction values, bus widths and the wait-counter load helper.
package mem_sequencer_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } state_t;

  typedef logic [2:0] wait_cnt_t;

  // Clamp a cycle-count parameter into the 1..7 range the 3-bit counter holds.
  function automatic wait_cnt_t wait_load(input int unsigned n);
    if (n < 1) return wait_cnt_t'(1);
    if (n > 7) return wait_cnt_t'(7);
    return wait_cnt_t'(n);
  endfunction

endpackage

// File: rtl/mem_sequencer.sv
// Arbitrates instruction-fetch and data requests onto a single combinational
// RAM controller port, with setup/pulse/hold sequencing for writes.
module mem_sequencer
  import mem_sequencer_pkg::*;
#(
  parameter int unsigned READ_WAIT   = 2,
  parameter int unsigned WRITE_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_valid_o,

  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_valid_o,

  output logic              stall_req_o,

  output logic              ram_enable_o,
  output logic              ram_rw_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  state_t    state;
  state_t    state_next;
  wait_cnt_t wait_cnt;
  logic      op_fetch;
  logic      d_done;
  logic      i_done;

  logic      mem_pending;
  logic      if_pending;
  logic      accept_mem;
  logic      accept_if;
  logic      last_wait;
  logic      rd_done;
  logic      wr_done;

  // A request stays pending until served; the done flag masks it while the
  // pipeline is still stalled on the other request.
  assign mem_pending = mem_req_i & ~d_done & ~mem_valid_o;
  assign if_pending  = if_req_i  & ~i_done & ~if_valid_o;
  assign stall_req_o = mem_pending | if_pending;

  assign accept_mem = (state == IDLE) & mem_pending;
  assign accept_if  = (state == IDLE) & ~mem_pending & if_pending;

  assign last_wait = (wait_cnt == wait_cnt_t'(1));
  assign rd_done   = (state == READ)     & last_wait;
  assign wr_done   = (state == WR_PULSE) & last_wait;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept_mem) begin
          state_next = mem_we_i ? WR_SETUP : READ;
        end else if (accept_if) begin
          state_next = READ;
        end
      end
      READ:     if (last_wait) state_next = IDLE;
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: if (last_wait) state_next = WR_HOLD;
      WR_HOLD:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_enable_o = 1'b0;
    ram_rw_o     = MEM_READ;
    unique case (state)
      READ:     ram_enable_o = 1'b1;
      WR_SETUP: ram_rw_o     = MEM_WRITE;
      WR_PULSE: begin
        ram_enable_o = 1'b1;
        ram_rw_o     = MEM_WRITE;
      end
      WR_HOLD:  ram_rw_o     = MEM_WRITE;
      default:  ;
    endcase
  end

  // Loads on entry to a timed state and counts down to 1, never wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      unique case (state_next)
        READ:     wait_cnt <= wait_load(READ_WAIT);
        WR_PULSE: wait_cnt <= wait_load(WRITE_PULSE);
        default:  wait_cnt <= '0;
      endcase
    end else if (wait_cnt > wait_cnt_t'(1)) begin
      wait_cnt <= wait_cnt - wait_cnt_t'(1);
    end
  end

  // Address and store data are registered at acceptance and held untouched
  // through the whole access, which keeps them stable from setup to hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      op_fetch    <= 1'b0;
    end else if (accept_mem) begin
      ram_addr_o  <= mem_addr_i;
      ram_wdata_o <= mem_wdata_i;
      op_fetch    <= 1'b0;
    end else if (accept_if) begin
      ram_addr_o  <= if_addr_i;
      op_fetch    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_inst_o   <= '0;
      mem_rdata_o <= '0;
      if_valid_o  <= 1'b0;
      mem_valid_o <= 1'b0;
    end else begin
      if_valid_o  <= rd_done & op_fetch;
      mem_valid_o <= (rd_done & ~op_fetch) | wr_done;
      if (rd_done & op_fetch) begin
        if_inst_o <= ram_rdata_i;
      end
      if (rd_done & ~op_fetch) begin
        mem_rdata_o <= ram_rdata_i;
      end
    end
  end

  // Completion sets a flag for the valid cycle and beyond; it clears only
  // once the pipeline is free to move, so a held request is not re-served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_done <= 1'b0;
      i_done <= 1'b0;
    end else begin
      if ((rd_done & ~op_fetch) | wr_done) begin
        d_done <= 1'b1;
      end else if (!stall_req_o) begin
        d_done <= 1'b0;
      end
      if (rd_done & op_fetch) begin
        i_done <= 1'b1;
      end else if (!stall_req_o) begin
        i_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: default-parameter instance for the main
// scenarios, a second instance with READ_WAIT=4, WRITE_PULSE=3.
module tb_mem_sequencer;

  logic        clk;
  logic        rst;

  logic        if_req, mem_req, mem_we;
  logic [17:0] if_addr, mem_addr;
  logic [15:0] mem_wdata, ram_rdata;
  logic [15:0] if_inst, mem_rdata, ram_wdata;
  logic        if_valid, mem_valid, stall, ram_en, ram_rw;
  logic [17:0] ram_addr;

  logic        p_if_req, p_mem_req, p_mem_we;
  logic [17:0] p_if_addr, p_mem_addr;
  logic [15:0] p_mem_wdata, p_ram_rdata;
  logic [15:0] p_if_inst, p_mem_rdata, p_ram_wdata;
  logic        p_if_valid, p_mem_valid, p_stall, p_ram_en, p_ram_rw;
  logic [17:0] p_ram_addr;

  int checks   = 0;
  int failures = 0;
  int en_cnt;
  int acc_cnt;

  mem_sequencer u_dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_inst_o    (if_inst),
    .if_valid_o   (if_valid),
    .mem_req_i    (mem_req),
    .mem_we_i     (mem_we),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .mem_rdata_o  (mem_rdata),
    .mem_valid_o  (mem_valid),
    .stall_req_o  (stall),
    .ram_enable_o (ram_en),
    .ram_rw_o     (ram_rw),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata)
  );

  mem_sequencer #(.READ_WAIT(4), .WRITE_PULSE(3)) u_dut_p (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (p_if_req),
    .if_addr_i    (p_if_addr),
    .if_inst_o    (p_if_inst),
    .if_valid_o   (p_if_valid),
    .mem_req_i    (p_mem_req),
    .mem_we_i     (p_mem_we),
    .mem_addr_i   (p_mem_addr),
    .mem_wdata_i  (p_mem_wdata),
    .mem_rdata_o  (p_mem_rdata),
    .mem_valid_o  (p_mem_valid),
    .stall_req_o  (p_stall),
    .ram_enable_o (p_ram_en),
    .ram_rw_o     (p_ram_rw),
    .ram_addr_o   (p_ram_addr),
    .ram_wdata_o  (p_ram_wdata),
    .ram_rdata_i  (p_ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Cycle k starts at posedge k; inputs change and outputs are sampled mid-cycle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0;
    mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
    p_if_req = 0; p_if_addr = '0; p_mem_req = 0; p_mem_we = 0;
    p_mem_addr = '0; p_mem_wdata = '0; p_ram_rdata = '0;

    // Reset state
    next_cycle(); #1;
    check("rst_en",     ram_en,    0);
    check("rst_rw",     ram_rw,    0);
    check("rst_addr",   ram_addr,  0);
    check("rst_wdata",  ram_wdata, 0);
    check("rst_inst",   if_inst,   0);
    check("rst_rdata",  mem_rdata, 0);
    check("rst_ivalid", if_valid,  0);
    check("rst_mvalid", mem_valid, 0);
    check("rst_stall",  stall,     0);
    next_cycle(); rst = 1'b1;

    // Fetch: accept at cycle 0, enable cycles 1-2, valid cycle 3
    next_cycle();
    if_req = 1; if_addr = 18'h00010; ram_rdata = 16'h4A21;
    #1;
    check("f0_stall", stall,  1);
    check("f0_en",    ram_en, 0);
    for (int c = 1; c <= 2; c++) begin
      next_cycle(); #1;
      check("f_en",     ram_en,   1);
      check("f_rw",     ram_rw,   0);
      check("f_addr",   ram_addr, 18'h00010);
      check("f_stall",  stall,    1);
      check("f_ivalid", if_valid, 0);
    end
    next_cycle(); #1;
    check("f3_ivalid", if_valid, 1);
    check("f3_inst",   if_inst,  16'h4A21);
    check("f3_stall",  stall,    0);
    check("f3_en",     ram_en,   0);
    next_cycle(); if_req = 0; ram_rdata = '0; #1;
    check("f4_ivalid", if_valid, 0);
    check("f4_inst",   if_inst,  16'h4A21);
    check("f4_en",     ram_en,   0);

    // Write: SETUP / PULSE / HOLD with stable address and data
    next_cycle();
    mem_req = 1; mem_we = 1; mem_addr = 18'h3FFFF; mem_wdata = 16'hBEEF;
    #1;
    check("w0_stall", stall, 1);
    en_cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); #1;
      en_cnt += int'(ram_en);
      check("w_addr",   ram_addr,  18'h3FFFF);
      check("w_wdata",  ram_wdata, 16'hBEEF);
      check("w_rw",     ram_rw,    1);
      check("w_en",     ram_en,    (c == 2) ? 1 : 0);
      check("w_mvalid", mem_valid, (c == 3) ? 1 : 0);
    end
    next_cycle(); mem_req = 0; mem_we = 0; #1;
    en_cnt += int'(ram_en);
    check("w4_en",     ram_en,    0);
    check("w4_rw",     ram_rw,    0);
    check("w4_mvalid", mem_valid, 0);
    check("w_pulses",  en_cnt,    1);

    // Data read with the request held through the valid cycle
    next_cycle();
    mem_req = 1; mem_addr = 18'h00123; ram_rdata = 16'h0F0F;
    for (int c = 1; c <= 2; c++) begin
      next_cycle(); #1;
      check("r_en", ram_en, 1);
    end
    next_cycle(); #1;
    check("r3_mvalid", mem_valid, 1);
    check("r3_rdata",  mem_rdata, 16'h0F0F);
    check("r3_en",     ram_en,    0);
    check("r3_stall",  stall,     0);
    next_cycle(); mem_req = 0; ram_rdata = '0; #1;
    check("r4_en", ram_en, 0);
    next_cycle(); #1;
    check("r5_en", ram_en, 0);

    // Simultaneous data read and fetch: data first, fetch next
    next_cycle();
    mem_req = 1; mem_we = 0; mem_addr = 18'h00200;
    if_req = 1; if_addr = 18'h00004; ram_rdata = 16'h1234;
    acc_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c == 3) ram_rdata = 16'h5678;
      #1;
      if (ram_en && ram_addr == 18'h00200) acc_cnt++;
      check("s_stall",  stall,     (c < 6) ? 1 : 0);
      check("s_mvalid", mem_valid, (c == 3) ? 1 : 0);
      check("s_ivalid", if_valid,  (c == 6) ? 1 : 0);
      check("s_en",     ram_en,    (c == 3 || c == 6) ? 0 : 1);
      if (ram_en) check("s_addr", ram_addr, (c < 3) ? 18'h00200 : 18'h00004);
    end
    check("s6_inst",  if_inst,   16'h5678);
    check("s6_rdata", mem_rdata, 16'h1234);
    next_cycle(); mem_req = 0; if_req = 0; ram_rdata = '0; #1;
    if (ram_en && ram_addr == 18'h00200) acc_cnt++;
    check("s7_en",      ram_en,  0);
    check("s_data_acc", acc_cnt, 2);

    // Reset asserted during WR_PULSE
    next_cycle();
    mem_req = 1; mem_we = 1; mem_addr = 18'h15555; mem_wdata = 16'hA5A5;
    next_cycle();
    next_cycle(); #1;
    check("rp_en_before", ram_en, 1);
    rst = 1'b0; mem_req = 0; mem_we = 0;
    #1;
    check("rp_en",     ram_en,    0);
    check("rp_rw",     ram_rw,    0);
    check("rp_addr",   ram_addr,  0);
    check("rp_wdata",  ram_wdata, 0);
    check("rp_mvalid", mem_valid, 0);
    check("rp_inst",   if_inst,   0);
    check("rp_rdata",  mem_rdata, 0);
    next_cycle(); #1;
    check("rp_en_held", ram_en, 0);

    // Release with a fetch already pending: accepted on the first edge
    next_cycle();
    rst = 1'b1; if_req = 1; if_addr = 18'h2AAAA; ram_rdata = 16'h7777;
    #1;
    check("rl_en",     ram_en,   0);
    check("rl_rw",     ram_rw,   0);
    check("rl_addr",   ram_addr, 0);
    check("rl_ivalid", if_valid, 0);
    check("rl_stall",  stall,    1);
    next_cycle(); #1;
    check("rl1_en",   ram_en,   1);
    check("rl1_addr", ram_addr, 18'h2AAAA);
    next_cycle(); #1;
    check("rl2_en", ram_en, 1);
    next_cycle(); #1;
    check("rl3_ivalid", if_valid, 1);
    check("rl3_inst",   if_inst,  16'h7777);
    next_cycle(); if_req = 0; ram_rdata = '0;

    // READ_WAIT=4: valid at N+5
    next_cycle();
    p_mem_req = 1; p_mem_we = 0; p_mem_addr = 18'h00ABC; p_ram_rdata = 16'hC0DE;
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); #1;
      check("p_rd_en",     p_ram_en,    (c <= 4) ? 1 : 0);
      check("p_rd_mvalid", p_mem_valid, (c == 5) ? 1 : 0);
    end
    check("p_rd_rdata", p_mem_rdata, 16'hC0DE);
    next_cycle(); p_mem_req = 0; p_ram_rdata = '0;

    // WRITE_PULSE=3: exactly three enable-high cycles
    next_cycle();
    p_mem_req = 1; p_mem_we = 1; p_mem_addr = 18'h01000; p_mem_wdata = 16'h5A5A;
    en_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c == 6) begin
        p_mem_req = 0; p_mem_we = 0;
      end
      #1;
      en_cnt += int'(p_ram_en);
      check("p_wr_mvalid", p_mem_valid, (c == 5) ? 1 : 0);
    end
    check("p_wr_pulses", en_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
